// File: rtl/bus_slave_ram_pkg.sv
// -----------------------------------------------------------------------------
// bus_slave_ram_pkg
// Shared CPU-bus definitions used by the RAM responder:
//   - word address / word data widths and types
//   - access direction codes (READ / WRITE)
//   - active-low enable codes (ENABLE_ / DISABLE_)
//   - responder FSM state encoding (2 bits, kept beside the initiator codes)
//   - wait-state counter width and limit
//   - addr_in_range(): true when the upper address bits above the array
//     index are all zero
// -----------------------------------------------------------------------------
package bus_slave_ram_pkg;

  localparam int unsigned WORD_ADDR_W     = 30;
  localparam int unsigned WORD_DATA_W     = 32;
  localparam int unsigned WAIT_CNT_W      = 4;
  localparam int unsigned WAIT_STATES_MAX = 15;

  typedef logic [WORD_ADDR_W-1:0] word_addr_t;
  typedef logic [WORD_DATA_W-1:0] word_data_t;

  localparam logic READ     = 1'b1;
  localparam logic WRITE    = 1'b0;
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  typedef enum logic [1:0] {
    SLV_IDLE = 2'b00,
    SLV_WAIT = 2'b01,
    SLV_ACK  = 2'b10
  } slave_state_e;

  // An address is serviced only if nothing is set above the index field.
  function automatic logic addr_in_range(input word_addr_t addr,
                                         input int unsigned idx_w);
    return ((addr >> idx_w) == {WORD_ADDR_W{1'b0}});
  endfunction

endpackage

// File: rtl/bus_slave_ram_array.sv
// -----------------------------------------------------------------------------
// bus_slave_ram_array
// Single-port word array: synchronous write, asynchronous read. Kept as its
// own module so it can be replaced by a vendor block-RAM primitive.
// Contents are not reset.
// Ports:
//   clk      in   write clock
//   we       in   write enable (write on rising edge)
//   addr     in   ADDR_W-bit word index (shared by read and write)
//   wr_data  in   32-bit write data
//   rd_data  out  32-bit read data, combinational from addr
// -----------------------------------------------------------------------------
module bus_slave_ram_array
  import bus_slave_ram_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [WORD_DATA_W-1:0] wr_data,
  output logic [WORD_DATA_W-1:0] rd_data
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  word_data_t mem_r [0:DEPTH-1];

  // Synchronous write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wr_data;
    end
  end

  assign rd_data = mem_r[addr];

endmodule

// File: rtl/bus_slave_ram.sv
// -----------------------------------------------------------------------------
// bus_slave_ram
// Word-addressed RAM responder on the shared CPU bus with a programmable
// number of wait states. A request (s_cs_ and s_as_ both low on a rising
// edge while idle) is latched, WAIT_STATES cycles are spent in WAIT, then a
// single ACK cycle drives s_rdy_ low. Reads return array data during ACK;
// writes commit on the edge leaving ACK. Addresses with bits set above the
// array index are acknowledged but neither written nor read.
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous reset, active-low
//   s_cs_      in   chip select, active-low
//   s_as_      in   address strobe, active-low
//   s_rw       in   1 = read, 0 = write
//   s_addr     in   30-bit word address
//   s_wr_data  in   32-bit write data
//   s_rd_data  out  32-bit read data, zero whenever s_rdy_ is high
//   s_rdy_     out  ready, active-low, one cycle per access
// -----------------------------------------------------------------------------
module bus_slave_ram
  import bus_slave_ram_pkg::*;
#(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   s_cs_,
  input  logic                   s_as_,
  input  logic                   s_rw,
  input  logic [WORD_ADDR_W-1:0] s_addr,
  input  logic [WORD_DATA_W-1:0] s_wr_data,
  output logic [WORD_DATA_W-1:0] s_rd_data,
  output logic                   s_rdy_
);

  // Parameter sanity: the counter is only 4 bits wide.
  if (WAIT_STATES > WAIT_STATES_MAX) begin : g_wait_states_check
    $error("bus_slave_ram: WAIT_STATES must be in 0..15");
  end
  if ((ADDR_W < 1) || (ADDR_W > WORD_ADDR_W)) begin : g_addr_w_check
    $error("bus_slave_ram: ADDR_W must be in 1..30");
  end

  localparam logic [WAIT_CNT_W-1:0] WAIT_CNT = WAIT_CNT_W'(WAIT_STATES);

  slave_state_e           state_r;
  slave_state_e           state_s;
  logic [WAIT_CNT_W-1:0]  cnt_r;
  logic [WAIT_CNT_W-1:0]  cnt_s;
  logic [WORD_ADDR_W-1:0] addr_r;
  logic                   rw_r;
  logic [WORD_DATA_W-1:0] wr_data_r;
  logic                   rdy_r;
  logic                   req_s;
  logic                   latch_s;
  logic                   in_range_s;
  logic                   we_s;
  logic [WORD_DATA_W-1:0] array_rd_s;
  logic [WORD_DATA_W-1:0] rd_data_s;

  assign req_s      = (s_cs_ == ENABLE_) && (s_as_ == ENABLE_);
  assign in_range_s = addr_in_range(addr_r, ADDR_W);

  // Next-state, counter and request-capture decode.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    latch_s = 1'b0;
    case (state_r)
      SLV_IDLE: begin
        if (req_s) begin
          latch_s = 1'b1;
          cnt_s   = WAIT_CNT;
          if (WAIT_CNT != {WAIT_CNT_W{1'b0}}) begin
            state_s = SLV_WAIT;
          end else begin
            state_s = SLV_ACK;
          end
        end else begin
          state_s = SLV_IDLE;
        end
      end
      SLV_WAIT: begin
        // Leave when the counter shows 1, so exactly WAIT_STATES cycles
        // are spent here; guard against wrap if it is ever 0.
        if (cnt_r <= {{(WAIT_CNT_W-1){1'b0}}, 1'b1}) begin
          state_s = SLV_ACK;
          cnt_s   = {WAIT_CNT_W{1'b0}};
        end else begin
          state_s = SLV_WAIT;
          cnt_s   = cnt_r - {{(WAIT_CNT_W-1){1'b0}}, 1'b1};
        end
      end
      SLV_ACK: begin
        state_s = SLV_IDLE;
        cnt_s   = {WAIT_CNT_W{1'b0}};
      end
      default: begin
        state_s = SLV_IDLE;
        cnt_s   = {WAIT_CNT_W{1'b0}};
      end
    endcase
  end

  // Write strobe to the array: only in ACK, only for in-range writes.
  always_comb begin
    we_s = 1'b0;
    if ((state_r == SLV_ACK) && (rw_r == WRITE) && in_range_s) begin
      we_s = 1'b1;
    end else begin
      we_s = 1'b0;
    end
  end

  // Read data return path, zero outside the ready pulse so slaves can be
  // OR-combined.
  always_comb begin
    rd_data_s = {WORD_DATA_W{1'b0}};
    if ((rdy_r == ENABLE_) && (rw_r == READ) && in_range_s) begin
      rd_data_s = array_rd_s;
    end else begin
      rd_data_s = {WORD_DATA_W{1'b0}};
    end
  end

  // FSM state and wait counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= SLV_IDLE;
      cnt_r   <= {WAIT_CNT_W{1'b0}};
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Request latch: address, direction and write data of the accepted access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_r    <= {WORD_ADDR_W{1'b0}};
      rw_r      <= 1'b0;
      wr_data_r <= {WORD_DATA_W{1'b0}};
    end else if (latch_s) begin
      addr_r    <= s_addr;
      rw_r      <= s_rw;
      wr_data_r <= s_wr_data;
    end
  end

  // Registered ready: low exactly while the FSM sits in ACK.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdy_r <= DISABLE_;
    end else if (state_s == SLV_ACK) begin
      rdy_r <= ENABLE_;
    end else begin
      rdy_r <= DISABLE_;
    end
  end

  bus_slave_ram_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .we      (we_s),
    .addr    (addr_r[ADDR_W-1:0]),
    .wr_data (wr_data_r),
    .rd_data (array_rd_s)
  );

  assign s_rdy_    = rdy_r;
  assign s_rd_data = rd_data_s;

endmodule

// File: tb/tb_bus_slave_ram.sv
// -----------------------------------------------------------------------------
// tb_bus_slave_ram
// Directed bench for bus_slave_ram. Three instances with ADDR_W=10 and
// WAIT_STATES = 0, 1 and 3 (index 0, 1, 2), each with its own bus inputs and
// a shared reset. Inputs change 1 time unit after the rising edge; outputs
// are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_bus_slave_ram;

  localparam logic RD = 1'b1;
  localparam logic WR = 1'b0;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cs_v   [3];
  logic        as_v   [3];
  logic        rw_v   [3];
  logic [29:0] addr_v [3];
  logic [31:0] wd_v   [3];
  logic        rdy_w  [3];
  logic [31:0] rd_w   [3];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int ack_cyc  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  bus_slave_ram #(.ADDR_W(10), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .reset(reset), .s_cs_(cs_v[0]), .s_as_(as_v[0]), .s_rw(rw_v[0]),
    .s_addr(addr_v[0]), .s_wr_data(wd_v[0]), .s_rd_data(rd_w[0]), .s_rdy_(rdy_w[0]));

  bus_slave_ram #(.ADDR_W(10), .WAIT_STATES(1)) u_ws1 (
    .clk(clk), .reset(reset), .s_cs_(cs_v[1]), .s_as_(as_v[1]), .s_rw(rw_v[1]),
    .s_addr(addr_v[1]), .s_wr_data(wd_v[1]), .s_rd_data(rd_w[1]), .s_rdy_(rdy_w[1]));

  bus_slave_ram #(.ADDR_W(10), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .reset(reset), .s_cs_(cs_v[2]), .s_as_(as_v[2]), .s_rw(rw_v[2]),
    .s_addr(addr_v[2]), .s_wr_data(wd_v[2]), .s_rd_data(rd_w[2]), .s_rdy_(rdy_w[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // One bus access: one-cycle strobe, then wait (bounded) for the ready pulse.
  // Returns latency in cycles after the strobe cycle (0 = never came) and the
  // data seen on the ready cycle. Ends on the falling edge of the ready cycle.
  task automatic access(input int sel, input logic rw, input logic [29:0] addr,
                        input logic [31:0] wd, output int lat, output logic [31:0] rdata);
    lat   = 0;
    rdata = 32'd0;
    @(posedge clk); #1;
    cs_v[sel] = 1'b0; as_v[sel] = 1'b0; rw_v[sel] = rw; addr_v[sel] = addr; wd_v[sel] = wd;
    @(posedge clk); #1;
    cs_v[sel] = 1'b1; as_v[sel] = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (rdy_w[sel] == 1'b0) begin
        lat     = n;
        rdata   = rd_w[sel];
        ack_cyc = cyc;
        break;
      end
      check("rd_data_zero_while_not_ready", rd_w[sel], 32'd0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int          lat;
    int          c_first;
    int          pulses;
    int          first_n;
    logic [31:0] rdata;

    for (int i = 0; i < 3; i++) begin
      cs_v[i] = 1'b1; as_v[i] = 1'b1; rw_v[i] = RD; addr_v[i] = 30'd0; wd_v[i] = 32'd0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("reset_rdy", {31'd0, rdy_w[i]}, 32'd1);
      check("reset_rd_data", rd_w[i], 32'd0);
    end
    @(posedge clk); #1;
    reset = 1'b1;

    // WAIT_STATES=1: write then read 0x10
    access(1, WR, 30'h10, 32'hDEADBEEF, lat, rdata);
    check("ws1_write_latency", lat, 32'd2);
    check("ws1_write_ack_data", rdata, 32'd0);
    @(negedge clk);
    check("ws1_rdy_one_cycle", {31'd0, rdy_w[1]}, 32'd1);
    access(1, RD, 30'h10, 32'd0, lat, rdata);
    check("ws1_read_latency", lat, 32'd2);
    check("ws1_read_data", rdata, 32'hDEADBEEF);
    @(negedge clk);
    check("ws1_rd_data_after_ack", rd_w[1], 32'd0);

    // WAIT_STATES=0: back-to-back reads of 0 and 1
    access(0, WR, 30'h0, 32'h0000_1111, lat, rdata);
    check("ws0_write0_latency", lat, 32'd1);
    access(0, WR, 30'h1, 32'h2222_0000, lat, rdata);
    check("ws0_write1_latency", lat, 32'd1);
    access(0, RD, 30'h0, 32'd0, lat, rdata);
    check("ws0_read0_latency", lat, 32'd1);
    check("ws0_read0_data", rdata, 32'h0000_1111);
    c_first = ack_cyc;
    access(0, RD, 30'h1, 32'd0, lat, rdata);
    check("ws0_read1_latency", lat, 32'd1);
    check("ws0_read1_data", rdata, 32'h2222_0000);
    check("ws0_pulse_spacing", ack_cyc - c_first, 32'd2);

    // WAIT_STATES=3: second strobe during WAIT is ignored
    access(2, WR, 30'h8, 32'h0000_0088, lat, rdata);
    check("ws3_write8_latency", lat, 32'd4);
    @(posedge clk); #1;
    cs_v[2] = 1'b0; as_v[2] = 1'b0; rw_v[2] = WR; addr_v[2] = 30'h7; wd_v[2] = 32'h0000_0077;
    @(posedge clk); #1;
    addr_v[2] = 30'h8; wd_v[2] = 32'h0000_0BAD;
    pulses  = 0;
    first_n = 0;
    @(negedge clk);
    if (rdy_w[2] == 1'b0) begin pulses++; first_n = 1; end
    @(posedge clk); #1;
    cs_v[2] = 1'b1; as_v[2] = 1'b1;
    for (int n = 2; n <= 10; n++) begin
      @(negedge clk);
      if (rdy_w[2] == 1'b0) begin
        pulses++;
        if (first_n == 0) first_n = n;
      end
    end
    check("ws3_single_pulse", pulses, 32'd1);
    check("ws3_pulse_position", first_n, 32'd4);
    access(2, RD, 30'h7, 32'd0, lat, rdata);
    check("ws3_read7_data", rdata, 32'h0000_0077);
    access(2, RD, 30'h8, 32'd0, lat, rdata);
    check("ws3_read8_unchanged", rdata, 32'h0000_0088);

    // Out-of-range address 0x400
    access(1, WR, 30'h0, 32'd0, lat, rdata);
    access(1, WR, 30'h400, 32'h12345678, lat, rdata);
    check("oor_write_latency", lat, 32'd2);
    access(1, RD, 30'h400, 32'd0, lat, rdata);
    check("oor_read_latency", lat, 32'd2);
    check("oor_read_data", rdata, 32'd0);
    access(1, RD, 30'h0, 32'd0, lat, rdata);
    check("oor_alias_read_data", rdata, 32'd0);

    // Strobe without chip select
    @(posedge clk); #1;
    cs_v[1] = 1'b1; as_v[1] = 1'b0; rw_v[1] = WR; addr_v[1] = 30'h10; wd_v[1] = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    as_v[1] = 1'b1;
    pulses = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (rdy_w[1] == 1'b0) pulses++;
    end
    check("nocs_no_ready", pulses, 32'd0);
    access(1, RD, 30'h10, 32'd0, lat, rdata);
    check("nocs_data_kept", rdata, 32'hDEADBEEF);

    // Reset during WAIT of a write to addr 5
    access(2, WR, 30'h5, 32'hA5A5A5A5, lat, rdata);
    @(posedge clk); #1;
    cs_v[2] = 1'b0; as_v[2] = 1'b0; rw_v[2] = WR; addr_v[2] = 30'h5; wd_v[2] = 32'h1111_1111;
    @(posedge clk); #1;
    cs_v[2] = 1'b1; as_v[2] = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("rst_wait_rdy", {31'd0, rdy_w[2]}, 32'd1);
    check("rst_wait_rd_data", rd_w[2], 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    access(2, RD, 30'h5, 32'd0, lat, rdata);
    check("rst_wait_read_latency", lat, 32'd4);
    check("rst_wait_write_lost", rdata, 32'hA5A5A5A5);

    // Reset during ACK of a read: outputs drop immediately
    access(0, RD, 30'h1, 32'd0, lat, rdata);
    check("rst_ack_pre_latency", lat, 32'd1);
    reset = 1'b0;
    #1;
    check("rst_ack_rdy", {31'd0, rdy_w[0]}, 32'd1);
    check("rst_ack_rd_data", rd_w[0], 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    access(0, RD, 30'h1, 32'd0, lat, rdata);
    check("rst_ack_post_latency", lat, 32'd1);
    check("rst_ack_array_kept", rdata, 32'h2222_0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
